// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch (read-only) and
// load/store, with LS priority and a starvation guard that forces an IF grant.
module mem_port_arbiter #(
    parameter int  ADDR_W   = 16,
    parameter int  DATA_W   = 32,
    parameter int  MAX_WAIT = 4,
    localparam int WCW      = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_ack_o,
    output logic              ls_stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [2:0]        dbg_state_o,
    output logic [WCW-1:0]    dbg_wait_cnt_o
);

    // Handshake: a requester holds req high until its one-cycle ack; the memory side
    // sees mem_req held with stable we/addr/wdata until it returns mem_ack (data valid then).
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUSY_IF = 3'd1,
        S_BUSY_LS = 3'd2,
        S_RESP_IF = 3'd3,
        S_RESP_LS = 3'd4
    } state_t;

    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant_if;
    logic                w_grant_ls;
    logic                w_busy;
    logic [WCW-1:0]      r_wait_cnt;
    logic                r_if_ack;
    logic                r_ls_ack;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_ls   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A starved fetch overrides the normal LS-first order.
                if (if_req_i && (r_wait_cnt == WAIT_MAX)) begin
                    w_grant_if = 1'b1;
                end else if (ls_req_i) begin
                    w_grant_ls = 1'b1;
                end else if (if_req_i) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_if) begin
                    w_next_state = S_BUSY_IF;
                end else if (w_grant_ls) begin
                    w_next_state = S_BUSY_LS;
                end
            end
            S_BUSY_IF: if (mem_ack_i) w_next_state = S_RESP_IF;
            S_BUSY_LS: if (mem_ack_i) w_next_state = S_RESP_LS;
            S_RESP_IF: w_next_state = S_IDLE;
            S_RESP_LS: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    assign w_busy = (r_state == S_BUSY_IF) || (r_state == S_BUSY_LS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt  <= '0;
            r_if_ack    <= 1'b0;
            r_ls_ack    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_if_ack <= (r_state == S_BUSY_IF) && mem_ack_i;
            r_ls_ack <= (r_state == S_BUSY_LS) && mem_ack_i;

            if (w_grant_if) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr_i;
                r_mem_wdata <= '0;
            end else if (w_grant_ls) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= ls_we_i;
                r_mem_addr  <= ls_addr_i;
                r_mem_wdata <= ls_wdata_i;
            end else if (w_busy && mem_ack_i) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) begin
                    r_rdata <= mem_rdata_i;
                end
            end

            if (w_grant_if) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_IDLE) && if_req_i && (r_wait_cnt != WAIT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
        end
    end

    assign if_ack_o       = r_if_ack;
    assign ls_ack_o       = r_ls_ack;
    assign ls_stall_o     = ls_req_i & ~r_ls_ack;
    assign rdata_o        = r_rdata;
    assign mem_req_o      = r_mem_req;
    assign mem_we_o       = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;
    assign dbg_state_o    = r_state;
    assign dbg_wait_cnt_o = r_wait_cnt;

endmodule
